// File: rtl/hazard_pkg.sv
// Shared defaults and latency constants for the decode hazard scoreboard.
package hazard_pkg;

  localparam int NUM_REGS_DEF     = 8;
  localparam int NSRC_DEF         = 3;
  localparam int LAT_W_DEF        = 3;
  localparam int FLUSH_CYCLES_DEF = 1;
  localparam int CNT_W_DEF        = 16;

  // Producer latencies: ALU results forward immediately, loads one cycle later.
  localparam int ALU_FWD_LAT  = 0;
  localparam int ALU_WB_LAT   = 2;
  localparam int LOAD_FWD_LAT = 1;
  localparam int LOAD_WB_LAT  = 3;

  typedef enum logic [1:0] {
    ENT_DEC   = 2'd0,
    ENT_LOAD  = 2'd1,
    ENT_CLEAR = 2'd2
  } entry_op_e;

endpackage

// File: rtl/hazard_sb_entry.sv
// One architectural register's pending-result counters: forwardable and
// register-file-readable countdowns, each saturating at zero.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [LAT_W-1:0] fwd_lat,
  input  logic [LAT_W-1:0] wb_lat,
  output logic [LAT_W-1:0] fwd_cnt,
  output logic [LAT_W-1:0] wb_cnt
);

  entry_op_e        op;
  logic [LAT_W-1:0] wb_load;

  // A value cannot reach the register file before it is forwardable.
  assign wb_load = (wb_lat > fwd_lat) ? wb_lat : fwd_lat;

  always_comb begin
    op = ENT_DEC;
    if (clear) begin
      op = ENT_CLEAR;
    end else if (load) begin
      op = ENT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt <= '0;
      wb_cnt  <= '0;
    end else begin
      case (op)
        ENT_CLEAR: begin
          fwd_cnt <= '0;
          wb_cnt  <= '0;
        end
        ENT_LOAD: begin
          fwd_cnt <= fwd_lat;
          wb_cnt  <= wb_load;
        end
        default: begin
          if (fwd_cnt != '0) fwd_cnt <= fwd_cnt - 1'b1;
          if (wb_cnt != '0)  wb_cnt  <= wb_cnt - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register latency countdowns drive the
// decode stall, plus fetch-flush sequencing and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int NSRC         = NSRC_DEF,
  parameter int LAT_W        = LAT_W_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  localparam int REG_W       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [NSRC-1:0]       id_src_valid,
  input  logic [NSRC*REG_W-1:0] id_src_reg,
  input  logic [NSRC-1:0]       id_src_early,
  input  logic                  id_dst_valid,
  input  logic [REG_W-1:0]      id_dst_reg,
  input  logic [LAT_W-1:0]      id_fwd_lat,
  input  logic [LAT_W-1:0]      id_wb_lat,
  input  logic                  redirect,
  input  logic                  pipe_flush,
  output logic                  stall_decode,
  output logic                  flush_fetch,
  output logic                  issue,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int DEPTH = 1 << REG_W;
  localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [LAT_W-1:0] fwd_cnt [DEPTH];
  logic [LAT_W-1:0] wb_cnt  [DEPTH];
  logic [NSRC-1:0]  src_busy;
  logic [FL_W-1:0]  flush_cnt_reg;
  logic [CNT_W-1:0] stall_count_reg;

  // Unused encodings of a non-power-of-two register file read as idle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if (gi < NUM_REGS) begin : g_real
      hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (issue & id_dst_valid & (id_dst_reg == REG_W'(gi))),
        .clear   (pipe_flush),
        .fwd_lat (id_fwd_lat),
        .wb_lat  (id_wb_lat),
        .fwd_cnt (fwd_cnt[gi]),
        .wb_cnt  (wb_cnt[gi])
      );
    end else begin : g_pad
      assign fwd_cnt[gi] = '0;
      assign wb_cnt[gi]  = '0;
    end
  end

  // Early sources are read in decode, so they must wait for the register file.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [REG_W-1:0] src;
    assign src          = id_src_reg[gi*REG_W +: REG_W];
    assign src_busy[gi] = id_src_valid[gi] &
                          ((id_src_early[gi] ? wb_cnt[src] : fwd_cnt[src]) != '0);
  end

  assign stall_decode = rst_n & id_valid & (|src_busy);
  assign flush_fetch  = rst_n & (redirect | (flush_cnt_reg != '0));
  assign issue        = id_valid & ~stall_decode & ~flush_fetch & ~pipe_flush;
  assign stall_count  = stall_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_reg <= '0;
    end else if (redirect) begin
      flush_cnt_reg <= FL_W'(FLUSH_CYCLES - 1);
    end else if (flush_cnt_reg != '0) begin
      flush_cnt_reg <= flush_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_reg <= '0;
    end else if (stall_decode && (stall_count_reg != '1)) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with fixed expectations and
// a randomized run against a timestamp-based readiness model.
module tb_hazard_scoreboard;

  localparam int NR = 8;
  localparam int NS = 3;
  localparam int LW = 3;
  localparam int FC = 2;
  localparam int CW = 5;
  localparam int RW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [NS-1:0] id_src_valid;
  logic [NS*RW-1:0] id_src_reg;
  logic [NS-1:0] id_src_early;
  logic          id_dst_valid;
  logic [RW-1:0] id_dst_reg;
  logic [LW-1:0] id_fwd_lat;
  logic [LW-1:0] id_wb_lat;
  logic          redirect;
  logic          pipe_flush;
  logic          stall_decode;
  logic          flush_fetch;
  logic          issue;
  logic [CW-1:0] stall_count;

  hazard_scoreboard #(
    .NUM_REGS(NR), .NSRC(NS), .LAT_W(LW), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_valid(id_src_valid),
    .id_src_reg(id_src_reg), .id_src_early(id_src_early), .id_dst_valid(id_dst_valid),
    .id_dst_reg(id_dst_reg), .id_fwd_lat(id_fwd_lat), .id_wb_lat(id_wb_lat),
    .redirect(redirect), .pipe_flush(pipe_flush), .stall_decode(stall_decode),
    .flush_fetch(flush_fetch), .issue(issue), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: absolute cycle at which each register becomes forwardable/readable.
  int now = 0;
  int fwd_ready [NR];
  int wb_ready  [NR];
  int flush_last = -1;
  int stall_m = 0;

  function automatic bit m_stall();
    bit s = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int r = int'(id_src_reg[i*RW +: RW]);
      if (id_src_valid[i]) begin
        if (id_src_early[i] ? (now < wb_ready[r]) : (now < fwd_ready[r])) s = 1'b1;
      end
    end
    return id_valid && s;
  endfunction

  function automatic bit m_flush();
    return redirect || (now <= flush_last);
  endfunction

  function automatic bit m_issue();
    return id_valid && !m_stall() && !m_flush() && !pipe_flush;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      fwd_ready[r] = 0;
      wb_ready[r]  = 0;
    end
    flush_last = -1;
    stall_m = 0;
  endtask

  // Advance one clock, applying this cycle's inputs to the model.
  task automatic tick();
    bit st = m_stall();
    bit is = m_issue();
    int d = int'(id_dst_reg);
    int f = int'(id_fwd_lat);
    int w = int'(id_wb_lat);
    @(posedge clk);
    if (st && stall_m < CNT_MAX) stall_m++;
    if (redirect) flush_last = now + FC - 1;
    if (pipe_flush) begin
      for (int r = 0; r < NR; r++) begin
        fwd_ready[r] = 0;
        wb_ready[r]  = 0;
      end
    end else if (is && id_dst_valid) begin
      fwd_ready[d] = now + 1 + f;
      wb_ready[d]  = now + 1 + ((w > f) ? w : f);
    end
    now++;
    #1;
  endtask

  task automatic set_instr(input bit v, input int s0, input int s1, input int s2,
                           input bit [2:0] early, input int dst, input int fl, input int wl);
    int s[3];
    s = '{s0, s1, s2};
    id_valid     = v;
    id_src_valid = '0;
    id_src_reg   = '0;
    for (int i = 0; i < NS; i++) begin
      if (s[i] >= 0) begin
        id_src_valid[i] = 1'b1;
        id_src_reg[i*RW +: RW] = RW'(s[i]);
      end
    end
    id_src_early = early;
    id_dst_valid = (dst >= 0);
    id_dst_reg   = (dst >= 0) ? RW'(dst) : '0;
    id_fwd_lat   = LW'(fl);
    id_wb_lat    = LW'(wl);
  endtask

  task automatic idle();
    set_instr(1'b0, -1, -1, -1, 3'b000, -1, 0, 0);
    redirect   = 1'b0;
    pipe_flush = 1'b0;
  endtask

  // Pulses reset between clock edges; called just after a rising edge.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle();
    id_valid = 1'b1;
    redirect = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({stall_decode, flush_fetch, issue} !== 3'b001) begin
      errors++;
      $display("FAIL reset_outputs: got stall/flush/issue=%b%b%b want 001", stall_decode, flush_fetch, issue);
    end
    checks++;
    if (stall_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", stall_count);
    end
    @(negedge clk);
    checks++;
    if (flush_fetch !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush_held: got %b want 0", flush_fetch);
    end
    $display("reset: stall=%b flush=%b issue=%b cnt=%0d", stall_decode, flush_fetch, issue, stall_count);
    #2 rst_n = 1'b1;
    idle();
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    bit [1:0] want [4] = '{2'b01, 2'b10, 2'b01, 2'b00};  // {stall, issue}
    do_reset();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       set_instr(1'b1, -1, -1, -1, 3'b000, 1, hazard_pkg::LOAD_FWD_LAT, hazard_pkg::LOAD_WB_LAT);
        1, 2:    set_instr(1'b1, 1, 3, -1, 3'b000, 2, hazard_pkg::ALU_FWD_LAT, hazard_pkg::ALU_WB_LAT);
        default: idle();
      endcase
      @(negedge clk);
      checks++;
      if ({stall_decode, issue} !== want[c]) begin
        errors++;
        $display("FAIL load_use c%0d: got stall/issue=%b%b want %b", c, stall_decode, issue, want[c]);
      end
      $display("load_use c%0d: stall=%b issue=%b cnt=%0d", c, stall_decode, issue, stall_count);
      tick();
    end
    checks++;
    if (stall_count !== 5'd1) begin
      errors++;
      $display("FAIL load_use_count: got %0d want 1", stall_count);
    end
  endtask

  task automatic test_early_branch();
    bit [1:0] want [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:          set_instr(1'b1, -1, -1, -1, 3'b000, 1, 1, 3);
        1, 2, 3, 4: set_instr(1'b1, 1, -1, -1, 3'b001, -1, 0, 0);
        default:    idle();
      endcase
      @(negedge clk);
      checks++;
      if ({stall_decode, issue} !== want[c]) begin
        errors++;
        $display("FAIL early_branch c%0d: got stall/issue=%b%b want %b", c, stall_decode, issue, want[c]);
      end
      $display("early_branch c%0d: stall=%b issue=%b cnt=%0d", c, stall_decode, issue, stall_count);
      tick();
    end
    checks++;
    if (stall_count !== 5'd3) begin
      errors++;
      $display("FAIL early_branch_count: got %0d want 3", stall_count);
    end
  endtask

  task automatic test_redirect();
    bit rd   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit want [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_instr(1'b1, -1, -1, -1, 3'b000, -1, 0, 0);
      redirect = rd[c];
      @(negedge clk);
      checks++;
      if ({flush_fetch, issue} !== {want[c], ~want[c]}) begin
        errors++;
        $display("FAIL redirect c%0d: got flush/issue=%b%b want %b%b", c, flush_fetch, issue, want[c], ~want[c]);
      end
      $display("redirect c%0d: redirect=%b flush=%b issue=%b", c, redirect, flush_fetch, issue);
      tick();
    end
    idle();
  endtask

  task automatic test_jal_jr();
    bit [1:0] want [6] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0, 4:    set_instr(1'b1, -1, -1, -1, 3'b000, 7, hazard_pkg::ALU_FWD_LAT, hazard_pkg::ALU_WB_LAT);
        1, 2, 3: set_instr(1'b1, 7, -1, -1, 3'b001, -1, 0, 0);
        default: set_instr(1'b1, 7, 7, -1, 3'b000, 3, 0, 2);
      endcase
      @(negedge clk);
      checks++;
      if ({stall_decode, issue} !== want[c]) begin
        errors++;
        $display("FAIL jal_jr c%0d: got stall/issue=%b%b want %b", c, stall_decode, issue, want[c]);
      end
      $display("jal_jr c%0d: stall=%b issue=%b", c, stall_decode, issue);
      tick();
    end
    idle();
  endtask

  task automatic test_pipe_flush();
    bit [1:0] want [3] = '{2'b01, 2'b10, 2'b01};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) set_instr(1'b1, -1, -1, -1, 3'b000, 2, 1, 3);
      else        set_instr(1'b1, 2, -1, -1, 3'b001, 2, 3, 3);
      pipe_flush = (c == 1);
      @(negedge clk);
      checks++;
      if ({stall_decode, issue} !== want[c]) begin
        errors++;
        $display("FAIL pipe_flush c%0d: got stall/issue=%b%b want %b", c, stall_decode, issue, want[c]);
      end
      $display("pipe_flush c%0d: flush=%b stall=%b issue=%b", c, pipe_flush, stall_decode, issue);
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_instr(1'b1, -1, -1, -1, 3'b000, 1, 7, 7);
    tick();
    set_instr(1'b1, 1, -1, -1, 3'b001, -1, 0, 0);
    @(negedge clk);
    checks++;
    if (stall_decode !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall_pre: got stall=%b want 1", stall_decode);
    end
    #1 rst_n = 1'b0;
    redirect = 1'b1;
    #1;
    checks++;
    if ({stall_decode, flush_fetch, issue, stall_count} !== {3'b001, 5'd0}) begin
      errors++;
      $display("FAIL mid_stall_reset: got stall/flush/issue=%b%b%b cnt=%0d want 001 cnt=0",
               stall_decode, flush_fetch, issue, stall_count);
    end
    $display("mid_stall: reset asserted stall=%b issue=%b cnt=%0d", stall_decode, issue, stall_count);
    redirect = 1'b0;
    #1 rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    now++;
    #1;
    @(negedge clk);
    checks++;
    if ({stall_decode, issue} !== 2'b01) begin
      errors++;
      $display("FAIL mid_stall_after: got stall/issue=%b%b want 01", stall_decode, issue);
    end
    $display("mid_stall: after reset stall=%b issue=%b", stall_decode, issue);
    tick();
    idle();
  endtask

  // Self-dependent early read/write of r1 with long latency keeps re-stalling.
  task automatic test_saturate();
    do_reset();
    for (int c = 0; c < 48; c++) begin
      set_instr(1'b1, 1, -1, -1, 3'b001, 1, 7, 7);
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (stall_decode !== 1'b0) begin
          errors++;
          $display("FAIL self_dep_first: got stall=%b want 0", stall_decode);
        end
      end
      checks++;
      if ({stall_decode, issue, stall_count} !== {m_stall(), m_issue(), CW'(stall_m)}) begin
        errors++;
        $display("FAIL saturate c%0d: got stall/issue=%b%b cnt=%0d want %b%b cnt=%0d",
                 c, stall_decode, issue, stall_count, m_stall(), m_issue(), stall_m);
      end
      $display("saturate c%0d: stall=%b issue=%b cnt=%0d", c, stall_decode, issue, stall_count);
      tick();
    end
    checks++;
    if (stall_count !== 5'd31) begin
      errors++;
      $display("FAIL saturate_final: got %0d want 31", stall_count);
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 0) do_reset();
      set_instr($urandom_range(0, 4) != 0,
                ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      redirect   = ($urandom_range(0, 9) == 0);
      pipe_flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      checks++;
      if ({stall_decode, flush_fetch, issue, stall_count} !==
          {m_stall(), m_flush(), m_issue(), CW'(stall_m)}) begin
        errors++;
        $display("FAIL random c%0d: got s/f/i=%b%b%b cnt=%0d want %b%b%b cnt=%0d",
                 c, stall_decode, flush_fetch, issue, stall_count,
                 m_stall(), m_flush(), m_issue(), stall_m);
      end
      $display("random c%0d: s/f/i=%b%b%b cnt=%0d", c, stall_decode, flush_fetch, issue, stall_count);
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_early_branch();
    test_redirect();
    test_jal_jr();
    test_pipe_flush();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, architectural register count; REG_W = clog2(NUM_REGS).
REQ-002 SHALL have parameter NSRC, default 3, source operands checked per decode instruction (rs, rt, store-data rd).
REQ-003 SHALL have parameter LAT_W, default 3, latency counter width.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 1, minimum 1, fetch-flush length per redirect.
REQ-005 SHALL have parameter CNT_W, default 16, stall performance counter width.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 id_valid  in  1  decode holds a real instruction.
REQ-009 id_src_valid  in  NSRC  per-source read enable.
REQ-010 id_src_reg  in  NSRC*REG_W  source register numbers, source i at [i*REG_W +: REG_W].
REQ-011 id_src_early  in  NSRC  source consumed in decode (branch/jr/jalr), no forwarding available.
REQ-012 id_dst_valid  in  1  instruction writes a register (includes lbi/slbi/stu Rs, jal/jalr R7).
REQ-013 id_dst_reg  in  REG_W  destination register.
REQ-014 id_fwd_lat  in  LAT_W  cycles until result is forwardable to execute.
REQ-015 id_wb_lat  in  LAT_W  cycles until result is readable from the register file.
REQ-016 redirect  in  1  taken branch/jump resolved this cycle.
REQ-017 pipe_flush  in  1  all in-flight writers squashed (exception/rti).
REQ-018 stall_decode  out  1  hold IF/ID, bubble into ID/EX.
REQ-019 flush_fetch  out  1  kill fetched instruction.
REQ-020 issue  out  1  instruction leaves decode this cycle.
REQ-021 stall_count  out  CNT_W  saturating count of stalled cycles.

Function
REQ-022 Per register SHALL hold fwd_cnt and wb_cnt (LAT_W bits each), decrementing by 1 per cycle, saturating at 0.
REQ-023 stall_decode SHALL be 1 iff id_valid and any i with id_src_valid[i] and (id_src_early[i] ? wb_cnt : fwd_cnt)[id_src_reg[i]] != 0; computed from registered counters only.
REQ-024 issue SHALL equal id_valid & ~stall_decode & ~flush_fetch & ~pipe_flush.
REQ-025 On issue with id_dst_valid, fwd_cnt[dst] SHALL load id_fwd_lat and wb_cnt[dst] SHALL load max(id_fwd_lat, id_wb_lat); load overrides decrement same cycle.
REQ-026 Instruction reading and writing the same register SHALL be checked against the pre-issue counter value.
REQ-027 pipe_flush SHALL clear every counter next edge, overriding a same-cycle load.
REQ-028 flush_fetch SHALL be 1 in the redirect cycle and the following FLUSH_CYCLES-1 cycles via a down-counter loaded with FLUSH_CYCLES-1; redirect during active flush reloads it.
REQ-029 stall_count SHALL increment each cycle stall_decode=1, saturating at all-ones; no wrap.
REQ-030 Latency 0 on a destination SHALL create no stall.

Reset
REQ-031 rst_n low SHALL immediately force all counters, flush counter and stall_count to 0; stall_decode, flush_fetch to 0; issue follows id_valid.
REQ-032 Reset mid-stall SHALL release the stall asynchronously; no pending hazard survives reset.

Structure
REQ-033 Package hazard_pkg SHALL hold parameter defaults and latency constants (ALU fwd 0/wb 2, load fwd 1/wb 3).
REQ-034 Sub-module hazard_sb_entry SHALL implement one register's counter pair (load, decrement, clear), instantiated NUM_REGS times.

Verification
REQ-035 Load r1 (fwd 1, wb 3) issues; next cycle add reads r1 -> stall_decode 1 for 1 cycle, issue on 2nd.
REQ-036 Load r1 (fwd 1, wb 3); next cycle beqz r1 (early) -> stall 3 cycles, stall_count increments by 3.
REQ-037 redirect pulse, FLUSH_CYCLES=2 -> flush_fetch high exactly 2 cycles, issue 0 both; second redirect in cycle 2 -> flush extends 2 cycles from it.
REQ-038 jal writes R7 (fwd 0, wb 2) then jr R7 -> 2-cycle stall; add R7 instead -> no stall.
REQ-039 Pending wb_cnt=3 on r2, pipe_flush asserted -> next cycle early read of r2 issues without stall.
REQ-040 rst_n dropped while stalled -> stall_decode 0 immediately, stall_count 0; stall_count forced near max -> saturates, no wrap.
